// File: rtl/axis_link_checker.sv
// AXI-Stream link sink/checker: constant or ramp payload check, packet-length check,
// saturating statistics and first-error capture. Optional tready throttle: AXIS_LINK_CHECKER_THROTTLE_EN.
module axis_link_checker #(
  parameter int                    DATA_WIDTH      = 128,
  parameter int                    MODE            = 1,
  parameter logic [DATA_WIDTH-1:0] MATCH_VALUE     = DATA_WIDTH'(1),
  parameter int                    PKT_LEN         = 16,
  parameter int                    CNT_W           = 32,
  parameter int                    THROTTLE_PERIOD = 4
) (
  input  logic                  link_clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_axis_link_tdata,
  input  logic                  s_axis_link_tlast,
  input  logic                  s_axis_link_tvalid,
  output logic                  s_axis_link_tready,
  output logic                  match,
  output logic                  err,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      first_err_beat
);

  localparam int          LANES    = DATA_WIDTH / 32;
  localparam logic [31:0] LAST_IDX = (PKT_LEN == 0) ? 32'd0 : 32'(PKT_LEN - 1);

  logic [31:0] exp_val, exp_next, idx, idx_next, lane0;
  logic        data_err, len_err, any_err, at_end, accept;
  logic [1:0]  err_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign accept = s_axis_link_tvalid & s_axis_link_tready;

  always_comb begin
    lane0    = s_axis_link_tdata[31:0];
    data_err = 1'b0;
    if (MODE == 0) begin
      data_err = (s_axis_link_tdata != MATCH_VALUE);
    end else begin
      for (int j = 0; j < LANES; j++) begin
        if (s_axis_link_tdata[32*j +: 32] != exp_val + 32'(j)) data_err = 1'b1;
      end
    end
    // A failed ramp beat resyncs on its own lane0 so one discontinuity costs one error.
    exp_next = data_err ? lane0 + 32'(LANES) : exp_val + 32'(LANES);

    at_end   = (idx == LAST_IDX);
    len_err  = 1'b0;
    idx_next = '0;
    if (PKT_LEN != 0) begin
      len_err  = (s_axis_link_tlast != at_end);
      idx_next = (s_axis_link_tlast || at_end) ? 32'd0 : idx + 32'd1;
    end
    any_err = data_err | len_err;
    err_inc = {1'b0, data_err} + {1'b0, len_err};
  end

`ifdef AXIS_LINK_CHECKER_THROTTLE_EN
  logic [31:0] tc, tc_next;

  assign tc_next = (tc == 32'(THROTTLE_PERIOD - 1)) ? 32'd0 : tc + 32'd1;

  // tready is low for exactly the cycle in which tc sits at its last count.
  always_ff @(posedge link_clk or posedge rst) begin
    if (rst) begin
      tc                 <= '0;
      s_axis_link_tready <= 1'b0;
    end else begin
      tc                 <= tc_next;
      s_axis_link_tready <= (tc_next != 32'(THROTTLE_PERIOD - 1));
    end
  end
`else
  always_ff @(posedge link_clk or posedge rst) begin
    if (rst) s_axis_link_tready <= 1'b0;
    else     s_axis_link_tready <= 1'b1;
  end
`endif

  always_ff @(posedge link_clk or posedge rst) begin
    if (rst) begin
      exp_val        <= '0;
      idx            <= '0;
      match          <= 1'b0;
      err            <= 1'b0;
      beat_cnt       <= '0;
      pkt_cnt        <= '0;
      err_cnt        <= '0;
      first_err_beat <= '0;
    end else if (clear) begin
      exp_val        <= '0;
      idx            <= '0;
      match          <= 1'b0;
      err            <= 1'b0;
      beat_cnt       <= '0;
      pkt_cnt        <= '0;
      err_cnt        <= '0;
      first_err_beat <= '0;
    end else if (accept) begin
      exp_val  <= exp_next;
      idx      <= idx_next;
      match    <= ~any_err;
      beat_cnt <= sat_add(beat_cnt, 2'd1);
      err_cnt  <= sat_add(err_cnt, err_inc);
      if (s_axis_link_tlast) pkt_cnt <= sat_add(pkt_cnt, 2'd1);
      if (any_err) begin
        err <= 1'b1;
        if (!err) first_err_beat <= beat_cnt;
      end
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_link_checker.sv
// Bench for axis_link_checker: ramp instance checked every cycle against a packet-level model,
// plus a constant-mode instance (narrow counters) driven from a vector table.
module tb_axis_link_checker;
  localparam int     P    = 4;
  localparam int     PLEN = 16;
  localparam longint MAXC = 64'hFFFF_FFFF;

  logic         link_clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0, tlast = 1'b0, tvalid = 1'b0;
  logic [127:0] tdata = '0;
  logic         tready, match, err;
  logic [31:0]  beat_cnt, pkt_cnt, err_cnt, first_err_beat;

  logic         c_clear = 1'b0, c_tlast = 1'b0, c_tvalid = 1'b0;
  logic [127:0] c_tdata = '0;
  logic         c_tready, c_match, c_err;
  logic [3:0]   c_beat_cnt, c_pkt_cnt, c_err_cnt, c_first_err_beat;

  always #5 link_clk = ~link_clk;

  axis_link_checker #(.DATA_WIDTH(128), .MODE(1), .PKT_LEN(PLEN), .CNT_W(32), .THROTTLE_PERIOD(P)) u_dut (
    .link_clk(link_clk), .rst(rst), .clear(clear),
    .s_axis_link_tdata(tdata), .s_axis_link_tlast(tlast), .s_axis_link_tvalid(tvalid),
    .s_axis_link_tready(tready), .match(match), .err(err),
    .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .first_err_beat(first_err_beat));

  axis_link_checker #(.DATA_WIDTH(128), .MODE(0), .MATCH_VALUE(128'd1), .PKT_LEN(0), .CNT_W(4),
                      .THROTTLE_PERIOD(P)) u_const (
    .link_clk(link_clk), .rst(rst), .clear(c_clear),
    .s_axis_link_tdata(c_tdata), .s_axis_link_tlast(c_tlast), .s_axis_link_tvalid(c_tvalid),
    .s_axis_link_tready(c_tready), .match(c_match), .err(c_err),
    .beat_cnt(c_beat_cnt), .pkt_cnt(c_pkt_cnt), .err_cnt(c_err_cnt), .first_err_beat(c_first_err_beat));

  int errors = 0;
  int checks = 0;

  // reference model of the ramp instance
  bit [31:0] m_exp;
  int        m_idx, n_edges;
  longint    m_beat, m_pkt, m_errc, m_ferr;
  bit        m_err, m_match, m_tready;

  typedef struct {
    logic [127:0] d;
    logic         v;
    logic         c;
    logic         m;
    int           errc;
    int           beat;
    logic         e;
    int           ferr;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic logic [127:0] ramp(input bit [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  function automatic bit tready_after(input int n);
`ifdef AXIS_LINK_CHECKER_THROTTLE_EN
    return (n % P) != (P - 1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_clear();
    m_exp = 0; m_idx = 0; m_beat = 0; m_pkt = 0; m_errc = 0; m_ferr = 0; m_err = 0; m_match = 0;
  endtask

  task automatic model_step(input logic [127:0] d, input logic l, input logic v, input logic c);
    bit derr, lerr;
    if (c) begin
      model_clear();
    end else if (v && m_tready) begin
      derr = (d != ramp(m_exp));
      lerr = (l != (m_idx == PLEN - 1));
      m_idx = (l || m_idx == PLEN - 1) ? 0 : m_idx + 1;
      if ((derr || lerr) && !m_err) begin
        m_ferr = m_beat;
        m_err  = 1;
      end
      m_errc  = sat(m_errc + longint'(derr) + longint'(lerr));
      m_beat  = sat(m_beat + 1);
      if (l) m_pkt = sat(m_pkt + 1);
      m_exp   = derr ? d[31:0] + 32'd4 : m_exp + 32'd4;
      m_match = !(derr || lerr);
    end else begin
      m_match = 0;
    end
  endtask

  // One clock on the ramp instance: drive at negedge, check outputs 1 ns after the edge.
  task automatic cyc(input logic [127:0] d, input logic l, input logic v, input logic c, output bit acc);
    tdata = d; tlast = l; tvalid = v; clear = c;
    chk("tready", tready, m_tready);
    acc = v && m_tready && !c;
    model_step(d, l, v, c);
    @(posedge link_clk);
    #1;
    n_edges++;
    m_tready = tready_after(n_edges);
    chk("match", match, m_match);
    chk("err", err, m_err);
    chk("beat_cnt", beat_cnt, m_beat);
    chk("pkt_cnt", pkt_cnt, m_pkt);
    chk("err_cnt", err_cnt, m_errc);
    chk("first_err_beat", first_err_beat, m_ferr);
    @(negedge link_clk);
    tvalid = 0; clear = 0;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cyc('0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    bit acc;
    int t = 0;
    do begin
      cyc(d, l, 1'b1, 1'b0, acc);
      t++;
    end while (!acc && t < 8);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge link_clk);
    rst = 1; tvalid = 0; clear = 0; c_tvalid = 0; c_clear = 0;
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err", err, 0);
    model_clear();
    m_tready = 0;
    n_edges = 0;
    @(posedge link_clk);
    @(negedge link_clk);
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [127:0] d;
    logic l;
    int k;

    tbl[0] = '{128'd1, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0, 0};
    tbl[1] = '{128'd2, 1'b1, 1'b0, 1'b0, 1, 2, 1'b1, 1};
    tbl[2] = '{128'd1, 1'b1, 1'b0, 1'b1, 1, 3, 1'b1, 1};
    tbl[3] = '{128'd2, 1'b0, 1'b0, 1'b0, 1, 3, 1'b1, 1};
    tbl[4] = '{128'd2, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0};
    tbl[5] = '{128'd2, 1'b1, 1'b0, 1'b0, 1, 1, 1'b1, 0};

    do_reset();
    idle(1);
    chk("tready_up", tready, 1);

    // two clean ramp packets
    for (int i = 0; i < 32; i++) begin
      send(ramp(32'(4 * i)), (i % 16) == 15);
      chk("ramp_match", match, 1);
    end
    chk("ramp_beats", beat_cnt, 32);
    chk("ramp_pkts", pkt_cnt, 2);
    chk("ramp_errs", err_cnt, 0);
    chk("ramp_err", err, 0);

    // single discontinuity on the 5th beat
    do_reset();
    for (int i = 0; i < 16; i++) begin
      k = (i < 4) ? 4 * i : ((i == 4) ? 100 : 104 + 4 * (i - 5));
      send(ramp(32'(k)), i == 15);
    end
    chk("disc_err_cnt", err_cnt, 1);
    chk("disc_first_err", first_err_beat, 4);
    chk("disc_err", err, 1);

    // early tlast followed by a correct packet
    do_reset();
    for (int i = 0; i < 26; i++) begin
      send(ramp(32'(4 * i)), i == 9 || i == 25);
      if (i > 9) chk("len_second_match", match, 1);
    end
    chk("len_err_cnt", err_cnt, 1);
    chk("len_pkt_cnt", pkt_cnt, 2);
    chk("len_first_err", first_err_beat, 9);

    // clear colliding with an accepted beat
    while (!m_tready) idle(1);
    cyc(ramp(32'd999), 1'b1, 1'b1, 1'b1, acc);
    chk("clr_beats", beat_cnt, 0);
    chk("clr_errs", err_cnt, 0);
    chk("clr_err", err, 0);
    send(ramp(32'd0), 1'b0);
    chk("clr_next_match", match, 1);

    // reset in the middle of a packet
    for (int i = 1; i < 5; i++) send(ramp(32'(4 * i)), 1'b0);
    do_reset();
    for (int i = 0; i < 16; i++) send(ramp(32'(4 * i)), i == 15);
    chk("rstmid_errs", err_cnt, 0);
    chk("rstmid_beats", beat_cnt, 16);
    chk("rstmid_pkts", pkt_cnt, 1);

`ifdef AXIS_LINK_CHECKER_THROTTLE_EN
    do_reset();
    idle(1);
    for (int i = 0; i < 40; i++) cyc(ramp(m_exp), m_idx == PLEN - 1, 1'b1, 1'b0, acc);
    chk("thr_beats", beat_cnt, 30);
    chk("thr_errs", err_cnt, 0);
    for (int i = 0; i < 5; i++) cyc(ramp(m_exp), m_idx == PLEN - 1, 1'b1, 1'b0, acc);
    do_reset();
`endif

    // randomized traffic with corruption, random tlast and occasional clear
    do_reset();
    for (int i = 0; i < 800; i++) begin
      d = ramp(m_exp);
      if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 127)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) d = ramp($urandom);
      l = (m_idx == PLEN - 1) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
      cyc(d, l, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, acc);
    end

    // constant-mode vector table
    do_reset();
    idle(1);
    for (int i = 0; i < 6; i++) begin
      while (!m_tready) idle(1);
      c_tdata = tbl[i].d; c_tvalid = tbl[i].v; c_clear = tbl[i].c; c_tlast = 1'b0;
      idle(1);
      c_tvalid = 0; c_clear = 0;
      chk($sformatf("const_match[%0d]", i), c_match, tbl[i].m);
      chk($sformatf("const_errc[%0d]", i), c_err_cnt, tbl[i].errc);
      chk($sformatf("const_beat[%0d]", i), c_beat_cnt, tbl[i].beat);
      chk($sformatf("const_err[%0d]", i), c_err, tbl[i].e);
      chk($sformatf("const_ferr[%0d]", i), c_first_err_beat, tbl[i].ferr);
    end

    // saturation on the 4-bit counters
    for (int i = 0; i < 16; i++) begin
      while (!m_tready) idle(1);
      c_tdata = 128'd2; c_tvalid = 1; c_tlast = 1;
      idle(1);
      c_tvalid = 0; c_tlast = 0;
    end
    chk("sat_beat", c_beat_cnt, 15);
    chk("sat_err", c_err_cnt, 15);
    chk("sat_pkt", c_pkt_cnt, 15);
    chk("sat_ferr", c_first_err_beat, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_link_checker.md
# axis_link_checker

Parametrised AXI-Stream sink/checker for the DMA-to-link path; next generation of the single-word link test sink. It accepts beats on the link clock, checks payload against a constant or ramp pattern, checks packet length on tlast, and keeps saturating beat, packet and error counters plus a first-error capture for debug readout. It sits at the DMA output in test builds, in place of the real link consumer.

## Interface
- DATA_WIDTH, 128: tdata width; multiple of 32; lanes L = DATA_WIDTH/32.
- MODE, 1: 0 = constant match, 1 = ramp check.
- MATCH_VALUE, 1: constant compared in MODE 0; zero-extended to DATA_WIDTH.
- PKT_LEN, 16: expected beats per packet; 0 disables the length check.
- CNT_W, 32: width of every counter output.
- THROTTLE_PERIOD, 4: tready throttle period, ≥2; used only with the throttle macro.
- link_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of counters, sticky flags and expected value.
- s_axis_link_tdata  in  DATA_WIDTH  payload.
- s_axis_link_tlast  in  1  end of packet.
- s_axis_link_tvalid  in  1  beat valid.
- s_axis_link_tready  out  1  sink ready, registered.
- match  out  1  one-cycle pulse: accepted beat passed its check.
- err  out  1  sticky: any data or length error since reset/clear.
- beat_cnt  out  CNT_W  accepted beats.
- pkt_cnt  out  CNT_W  accepted tlast beats.
- err_cnt  out  CNT_W  error events (data and length counted separately).
- first_err_beat  out  CNT_W  beat_cnt value at the first error; held until clear.

## Operation
- Handshake: beat accepted when tvalid & tready at the link_clk edge. tdata/tlast are ignored otherwise.
- MODE 0: pass if tdata == MATCH_VALUE; else data error.
- MODE 1: expected value exp (32 bit) starts at 0. Pass if every lane j (tdata[32j+31:32j]) equals exp + j (mod 2^32). On pass, exp <= exp + L. On fail, data error and resync: exp <= lane0 + L. A single discontinuity therefore yields one error.
- Length check (PKT_LEN≠0): in-packet beat index idx starts at 0.
  - tlast on idx == PKT_LEN-1 is correct; idx returns to 0.
  - tlast early, or no tlast at idx == PKT_LEN-1: length error; idx returns to 0.
- A beat with both data and length errors adds 2 to err_cnt.
- match is high only if the beat had no data or length error.
- Counters saturate at all-ones, with no wrap. pkt_cnt counts every tlast beat regardless of errors.
- first_err_beat captures the pre-increment beat_cnt on the first error after reset/clear.
- clear and an accepted beat in the same cycle: clear wins and the beat is discarded from all statistics. exp, idx and all counters become 0; err and first_err_beat become 0.
- Reset mid-packet: all state returns to reset values. The next accepted beat is treated as idx 0 with exp 0.

## Timing
- Reset values: s_axis_link_tready 0, match 0, err 0, all counters 0, first_err_beat 0, exp 0, idx 0.
- s_axis_link_tready goes 1 on the first link_clk edge after rst deasserts. It stays 1, except for the throttle behaviour described under Configuration.
- Latency: all outputs are registered. match, err and the counters reflect a beat accepted at edge N from edge N+1. Throughput is one beat per cycle.
- clear takes effect at the edge where it is sampled high. tready is unaffected by clear.

## Configuration
- AXIS_LINK_CHECKER_THROTTLE_EN defined:
  - A free-running counter tc cycles 0..THROTTLE_PERIOD-1 and starts at 0 out of reset.
  - s_axis_link_tready is registered low for the cycle where tc == THROTTLE_PERIOD-1, giving (P-1)/P acceptance. This exercises upstream backpressure.
- Undefined: no throttle logic; tready is constant 1 after reset.

## Test plan
- Reset, then ramp packets: MODE 1, 2 packets of 16 beats with lanes {4k+3, 4k+2, 4k+1, 4k} -> beat_cnt 32, pkt_cnt 2, err_cnt 0, err 0, match high on each accepted beat.
- Ramp discontinuity: the 5th beat has lane0 = 100 and the following beats continue from 104 -> exactly one data error; err_cnt 1, first_err_beat 4, err sticky.
- Length error: tlast on the 10th beat with PKT_LEN 16, then a correct 16-beat packet -> err_cnt 1, pkt_cnt 2; the second packet has no errors.
- Constant mode: MODE 0, beats 1, 2, 1 -> match pulses on beats 1 and 3, err_cnt 1.
- Clear collision: clear is high in the same cycle as an accepted beat after errors -> all counters 0, err 0, and the next ramp beat with lane0 = 0 passes.
- Throttle build: THROTTLE_PERIOD 4, tvalid held high for 40 cycles -> tready low every 4th cycle, beat_cnt 30, no errors; rst asserted mid-burst -> tready 0 immediately and all counters 0.
